ac_rle_scanner: RTL

Sequential JPEG AC run-length scanner. Accepts one quantised 8x8 coefficient block per handshake, walks the 63 AC positions, and emits one JPEG symbol per output handshake: (run, size, amplitude), ZRL (15/0), or EOB (0/0). It is the parametrised, signed, back-pressured successor of the fixed single-symbol AC encoder step, and feeds the Huffman table lookup stage.

---
 rtl/jpeg_enc_pkg.sv | 28 ++
 rtl/ac_size_amp.sv | 31 +++
 rtl/ac_rle_scanner.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder types and constants: field widths, ZRL run,
// scanner state encoding and the zigzag scan table.
package jpeg_enc_pkg;

   localparam int RUN_W  = 4;
   localparam int SIZE_W = 4;

   localparam logic [RUN_W-1:0] ZRL_RUN = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Scan index -> row-major element index.
   localparam logic [5:0] ZIGZAG [0:63] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage

// File: rtl/ac_size_amp.sv
// Magnitude category and right-aligned amplitude bits of one signed
// coefficient; shared by the AC scanner and the DC path.
module ac_size_amp
   import jpeg_enc_pkg::*;
#(
   parameter int COEF_W = 8
) (
   input  logic [COEF_W-1:0] coef,
   output logic [SIZE_W-1:0] size,
   output logic [COEF_W-1:0] amp
);

   logic [COEF_W:0] ext;
   logic [COEF_W:0] mag;
   logic [COEF_W:0] adj;
   logic [COEF_W:0] keep;

   always_comb begin
      ext = {coef[COEF_W-1], coef};
      // One extra bit keeps the most negative value's magnitude exact.
      mag = coef[COEF_W-1] ? (~ext + (COEF_W+1)'(1)) : ext;
      size = '0;
      for (int i = 0; i < COEF_W; i++) begin
         if (mag[i]) size = SIZE_W'(i + 1);
      end
      adj  = coef[COEF_W-1] ? (ext - (COEF_W+1)'(1)) : ext;
      keep = ((COEF_W+1)'(1) << size) - (COEF_W+1)'(1);
      amp  = adj[COEF_W-1:0] & keep[COEF_W-1:0];
   end

endmodule

// File: rtl/ac_rle_scanner.sv
// JPEG AC run-length scanner: one 8x8 block in, (run,size,amp)/ZRL/EOB out.
// Define AC_RLE_ZIGZAG_EN for zigzag order; otherwise natural row-major.
module ac_rle_scanner
   import jpeg_enc_pkg::*;
#(
   parameter int COEF_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [64*COEF_W-1:0]  in_blk,
   input  logic                  in_is_luma,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [RUN_W-1:0]      out_run,
   output logic [SIZE_W-1:0]     out_size,
   output logic [COEF_W-1:0]     out_amp,
   output logic                  out_eob,
   output logic                  out_zrl,
   output logic                  out_last,
   output logic                  out_is_luma
);

   state_t                state;
   logic [64*COEF_W-1:0]  blk;
   logic [63:0]           mask;
   logic [63:0]           scan_mask;
   logic [63:0]           hi_mask;
   logic                  tag;
   logic [5:0]            k;
   logic [RUN_W-1:0]      run;
   logic [COEF_W-1:0]     coef;
   logic [SIZE_W-1:0]     c_size;
   logic [COEF_W-1:0]     c_amp;
   logic                  rem;
   logic                  is_zero;
   logic                  advance;

   function automatic logic [5:0] order_of(input logic [5:0] idx);
`ifdef AC_RLE_ZIGZAG_EN
      return ZIGZAG[idx];
`else
      return idx;
`endif
   endfunction

   assign in_ready = (state == ST_IDLE) && !rst;

   // Nonzero mask kept in scan order so the EOB test is a simple range OR.
   always_comb begin
      scan_mask = '0;
      for (int j = 1; j < 64; j++) begin
         scan_mask[j] = |in_blk[int'(order_of(6'(j)))*COEF_W +: COEF_W];
      end
   end

   always_comb begin
      coef    = blk[int'(order_of(k))*COEF_W +: COEF_W];
      hi_mask = ~((64'd1 << k) - 64'd1);
      rem     = |(mask & hi_mask);
      is_zero = (coef == '0);
      advance = (state == ST_SCAN) && (!out_valid || out_ready);
   end

   ac_size_amp #(
      .COEF_W (COEF_W)
   ) u_size_amp (
      .coef (coef),
      .size (c_size),
      .amp  (c_amp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         blk         <= '0;
         mask        <= '0;
         tag         <= 1'b0;
         k           <= 6'd1;
         run         <= '0;
         out_valid   <= 1'b0;
         out_run     <= '0;
         out_size    <= '0;
         out_amp     <= '0;
         out_eob     <= 1'b0;
         out_zrl     <= 1'b0;
         out_last    <= 1'b0;
         out_is_luma <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  blk   <= in_blk;
                  mask  <= scan_mask;
                  tag   <= in_is_luma;
                  k     <= 6'd1;
                  run   <= '0;
                  state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (out_valid && out_ready) out_valid <= 1'b0;
               if (advance) begin
                  if (!rem) begin
                     out_valid   <= 1'b1;
                     out_run     <= '0;
                     out_size    <= '0;
                     out_amp     <= '0;
                     out_eob     <= 1'b1;
                     out_zrl     <= 1'b0;
                     out_last    <= 1'b1;
                     out_is_luma <= tag;
                     state       <= ST_DRAIN;
                  end else if (is_zero && run == ZRL_RUN) begin
                     out_valid   <= 1'b1;
                     out_run     <= ZRL_RUN;
                     out_size    <= '0;
                     out_amp     <= '0;
                     out_eob     <= 1'b0;
                     out_zrl     <= 1'b1;
                     out_last    <= 1'b0;
                     out_is_luma <= tag;
                     run         <= '0;
                     k           <= k + 6'd1;
                  end else if (is_zero) begin
                     run <= run + 1'b1;
                     k   <= k + 6'd1;
                  end else begin
                     out_valid   <= 1'b1;
                     out_run     <= run;
                     out_size    <= c_size;
                     out_amp     <= c_amp;
                     out_eob     <= 1'b0;
                     out_zrl     <= 1'b0;
                     out_is_luma <= tag;
                     run         <= '0;
                     if (k == 6'd63) begin
                        out_last <= 1'b1;
                        state    <= ST_DRAIN;
                     end else begin
                        out_last <= 1'b0;
                        k        <= k + 6'd1;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
